// File: rtl/wino_pkg.sv
// Shared constants for the winograd1d F(2,3) datapath: tile geometry, default sample width
// and the tile-feeder state encoding.
package wino_pkg;

  localparam int unsigned WINO_DATA_W = 32;  // default sample/weight width
  localparam int unsigned TILE_N      = 4;   // samples per input tile
  localparam int unsigned STRIDE      = 2;   // new samples between overlapping tiles
  localparam int unsigned KERN_N      = 3;   // kernel taps

  // Tile-feeder states, plain constants so older tools can consume them too.
  typedef logic [1:0] feed_state_t;
  localparam feed_state_t EMPTY  = 2'd0;  // row start, no samples held
  localparam feed_state_t PRIME  = 2'd1;  // collecting the first full tile of a row
  localparam feed_state_t STEADY = 2'd2;  // overlapping tiles, STRIDE new samples each

endpackage

// File: rtl/wino_window_shift.sv
// Sample window for the tile feeder: DEPTH-entry shift register, new sample enters the top
// entry (index DEPTH-1), index 0 is the oldest. Synchronous clear wins over shift.
module wino_window_shift #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          shift_i,
  input  logic [DATA_W-1:0]             data_i,
  output logic [DEPTH-1:0][DATA_W-1:0]  win_o
);

  logic [DEPTH-1:0][DATA_W-1:0] win_d, win_q;

  // Next window: clear on row end, otherwise shift one sample in.
  always_comb begin
    win_d = win_q;
    if (clear_i) begin
      win_d = '0;
    end else if (shift_i) begin
      win_d = {data_i, win_q[DEPTH-1:1]};
    end
  end

  // Window storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign win_o = win_q;

endmodule

// File: rtl/winograd1d_tile_feeder.sv
// Upstream stage of winograd1d F(2,3): turns a serial sample stream into overlapping
// 4-sample tiles (stride 2) with a held 3-tap kernel. Rows are independent; the last tile
// of a row is zero-padded on the right when incomplete.
// Optional build macro WINO_FEED_STATS_EN adds tile_cnt/row_cnt handshake counters.
module winograd1d_tile_feeder
  import wino_pkg::*;
#(
  parameter int unsigned DATA_W = WINO_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in1,
  input  logic [DATA_W-1:0] w_in2,
  input  logic [DATA_W-1:0] w_in3,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_x1,
  output logic [DATA_W-1:0] m_x2,
  output logic [DATA_W-1:0] m_x3,
  output logic [DATA_W-1:0] m_x4,
  output logic [DATA_W-1:0] m_w1,
  output logic [DATA_W-1:0] m_w2,
  output logic [DATA_W-1:0] m_w3,
  output logic              m_last
`ifdef WINO_FEED_STATS_EN
  ,
  output logic [31:0]       tile_cnt,
  output logic [15:0]       row_cnt
`endif
);

  feed_state_t state_d, state_q;
  logic [1:0]  nc_d, nc_q;  // new samples since the last tile (or row start)

  logic [TILE_N-1:0][DATA_W-1:0] win;      // held window, [0] oldest
  logic [TILE_N-1:0][DATA_W-1:0] shifted;  // window including this cycle's sample
  logic [TILE_N-1:0][DATA_W-1:0] tile_new;
  logic [TILE_N-1:0][DATA_W-1:0] tile_d, tile_q;
  logic [KERN_N-1:0][DATA_W-1:0] w_d, w_q;

  logic       m_valid_d, m_valid_q;
  logic       m_last_d, m_last_q;
  logic       accept;
  logic       tile_full;
  logic       load_tile;
  logic       win_clear;
  logic       win_shift;
  logic       handshake;
  logic [2:0] v_cnt;  // valid samples that the emitted tile carries

  // A pending tile is never overwritten: input only flows when the output slot frees up.
  assign s_ready   = !m_valid_q | m_ready;
  assign accept    = s_valid & s_ready;
  assign handshake = m_valid_q & m_ready;
  assign shifted   = {s_data, win[3], win[2], win[1]};

  wino_window_shift #(
    .DATA_W (DATA_W),
    .DEPTH  (TILE_N)
  ) u_window (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (win_clear),
    .shift_i (win_shift),
    .data_i  (s_data),
    .win_o   (win)
  );

  // Row FSM and new-sample counter; decides when a tile is complete.
  always_comb begin
    state_d   = state_q;
    nc_d      = nc_q;
    tile_full = 1'b0;
    v_cnt     = 3'd4;
    case (state_q)
      EMPTY: begin
        v_cnt = 3'd1;
        if (accept) begin
          state_d = PRIME;
          nc_d    = 2'd1;
        end
      end
      PRIME: begin
        v_cnt = {1'b0, nc_q} + 3'd1;
        if (accept) begin
          if (nc_q == 2'(TILE_N - 1)) begin
            tile_full = 1'b1;
            state_d   = STEADY;
            nc_d      = 2'd0;
          end else begin
            nc_d = nc_q + 2'd1;
          end
        end
      end
      STEADY: begin
        if (accept) begin
          if (nc_q == 2'(STRIDE - 1)) begin
            tile_full = 1'b1;
            nc_d      = 2'd0;
          end else begin
            // One new sample past the previous tile's overlap: three real samples.
            v_cnt = 3'd3;
            nc_d  = nc_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        nc_d    = 2'd0;
      end
    endcase
    // Row end: restart cleanly, nothing carries into the next row.
    if (accept && s_last) begin
      state_d = EMPTY;
      nc_d    = 2'd0;
    end
  end

  assign load_tile = accept & (tile_full | s_last);
  assign win_clear = accept & s_last;
  assign win_shift = accept & !s_last;

  // Left-align the valid samples of a short final tile and zero the tail.
  always_comb begin
    tile_new = shifted;
    case (v_cnt)
      3'd1:    tile_new = {{(3 * DATA_W){1'b0}}, shifted[3]};
      3'd2:    tile_new = {{(2 * DATA_W){1'b0}}, shifted[3], shifted[2]};
      3'd3:    tile_new = {{DATA_W{1'b0}}, shifted[3], shifted[2], shifted[1]};
      default: tile_new = shifted;
    endcase
  end

  // Output tile slot: reload on a new tile, drop valid on a bare handshake, else hold.
  always_comb begin
    tile_d    = tile_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    if (load_tile) begin
      tile_d    = tile_new;
      m_last_d  = s_last;
      m_valid_d = 1'b1;
    end else if (handshake) begin
      m_valid_d = 1'b0;
    end
  end

  // Kernel latch: only at a row boundary with nothing in flight, so a tile never mixes weights.
  always_comb begin
    w_d = w_q;
    if (w_load && (state_q == EMPTY) && !m_valid_q) begin
      w_d = {w_in3, w_in2, w_in1};
    end
  end

  // State, tile and kernel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      nc_q      <= 2'd0;
      tile_q    <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      w_q       <= '0;
    end else begin
      state_q   <= state_d;
      nc_q      <= nc_d;
      tile_q    <= tile_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
      w_q       <= w_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_x1    = tile_q[0];
  assign m_x2    = tile_q[1];
  assign m_x3    = tile_q[2];
  assign m_x4    = tile_q[3];
  assign m_w1    = w_q[0];
  assign m_w2    = w_q[1];
  assign m_w3    = w_q[2];

`ifdef WINO_FEED_STATS_EN
  logic [31:0] tile_cnt_d, tile_cnt_q;
  logic [15:0] row_cnt_d, row_cnt_q;

  // Handshake counters, free-running with natural wrap.
  always_comb begin
    tile_cnt_d = tile_cnt_q;
    row_cnt_d  = row_cnt_q;
    if (handshake) begin
      tile_cnt_d = tile_cnt_q + 32'd1;
      if (m_last_q) begin
        row_cnt_d = row_cnt_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_cnt_q <= 32'd0;
      row_cnt_q  <= 16'd0;
    end else begin
      tile_cnt_q <= tile_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  assign tile_cnt = tile_cnt_q;
  assign row_cnt  = row_cnt_q;
`endif

endmodule

// File: tb/tb_winograd1d_tile_feeder.sv
// Directed bench for winograd1d_tile_feeder: reset, tiling, padding, backpressure, kernel load.
module tb_winograd1d_tile_feeder;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        w_load;
  logic [31:0] w_in1, w_in2, w_in3;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_x1, m_x2, m_x3, m_x4;
  logic [31:0] m_w1, m_w2, m_w3;
  logic        m_last;

  int n_cmp = 0;
  int n_bad = 0;

  winograd1d_tile_feeder #(
    .DATA_W (32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .w_load  (w_load),
    .w_in1   (w_in1),
    .w_in2   (w_in2),
    .w_in3   (w_in3),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_x1    (m_x1),
    .m_x2    (m_x2),
    .m_x3    (m_x3),
    .m_x4    (m_x4),
    .m_w1    (m_w1),
    .m_w2    (m_w2),
    .m_w3    (m_w3),
    .m_last  (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tile(input string tag, input logic [31:0] x1, input logic [31:0] x2,
                          input logic [31:0] x3, input logic [31:0] x4, input logic last);
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_x1"}, m_x1, x1);
    chk({tag, "_x2"}, m_x2, x2);
    chk({tag, "_x3"}, m_x3, x3);
    chk({tag, "_x4"}, m_x4, x4);
    chk({tag, "_last"}, 32'(m_last), 32'(last));
  endtask

  // Offer one sample (called just after a rising edge); returns just after it is accepted.
  task automatic push(input logic [31:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    w_load  = 1'b0;
    w_in1   = '0;
    w_in2   = '0;
    w_in3   = '0;
    m_ready = 1'b1;

    // T1 reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_x1", m_x1, 32'd0);
    chk("rst_x4", m_x4, 32'd0);
    chk("rst_w1", m_w1, 32'd0);
    chk("rst_w3", m_w3, 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_sready", 32'(s_ready), 32'd1);
    idle_cycle();

    // T2 row 3,1,0,3,2,0
    push(32'd3, 1'b0);
    push(32'd1, 1'b0);
    push(32'd0, 1'b0);
    chk("t2_novalid3", 32'(m_valid), 32'd0);
    push(32'd3, 1'b0);
    chk_tile("t2_tile1", 32'd3, 32'd1, 32'd0, 32'd3, 1'b0);
    push(32'd2, 1'b0);
    chk("t2_novalid5", 32'(m_valid), 32'd0);
    push(32'd0, 1'b1);
    chk_tile("t2_tile2", 32'd0, 32'd3, 32'd2, 32'd0, 1'b1);
    idle_cycle();
    chk("t2_drained", 32'(m_valid), 32'd0);

    // T3 row 1..5 then 9,8,7,6
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    push(32'd3, 1'b0);
    push(32'd4, 1'b0);
    chk_tile("t3_tile1", 32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    push(32'd5, 1'b1);
    chk_tile("t3_pad", 32'd3, 32'd4, 32'd5, 32'd0, 1'b1);
    push(32'd9, 1'b0);
    push(32'd8, 1'b0);
    push(32'd7, 1'b0);
    chk("t3_noc_carry", 32'(m_valid), 32'd0);
    push(32'd6, 1'b1);
    chk_tile("t3_row2", 32'd9, 32'd8, 32'd7, 32'd6, 1'b1);
    idle_cycle();

    // T4 backpressure on 10..17
    push(32'd10, 1'b0);
    push(32'd11, 1'b0);
    push(32'd12, 1'b0);
    push(32'd13, 1'b0);
    m_ready = 1'b0;
    #1;
    chk("t4_sready_stall", 32'(s_ready), 32'd0);
    s_valid = 1'b1;
    s_data  = 32'd14;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_sready_held", 32'(s_ready), 32'd0);
    chk_tile("t4_stalled", 32'd10, 32'd11, 32'd12, 32'd13, 1'b0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("t4_released", 32'(m_valid), 32'd0);
    push(32'd15, 1'b0);
    chk_tile("t4_tile2", 32'd12, 32'd13, 32'd14, 32'd15, 1'b0);
    push(32'd16, 1'b0);
    push(32'd17, 1'b1);
    chk_tile("t4_tile3", 32'd14, 32'd15, 32'd16, 32'd17, 1'b1);
    idle_cycle();

    // T5 short rows
    push(32'd7, 1'b0);
    push(32'd8, 1'b1);
    chk_tile("t5_two", 32'd7, 32'd8, 32'd0, 32'd0, 1'b1);
    push(32'hFFFF_FFFB, 1'b1);
    chk_tile("t5_one", 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0, 1'b1);
    idle_cycle();

    // T6 kernel load, ignored load, reset mid-row
    w_load = 1'b1;
    w_in1  = 32'd0;
    w_in2  = 32'd1;
    w_in3  = 32'd2;
    @(posedge clk);
    #1;
    w_load = 1'b0;
    chk("t6_w1", m_w1, 32'd0);
    chk("t6_w2", m_w2, 32'd1);
    chk("t6_w3", m_w3, 32'd2);
    push(32'd20, 1'b0);
    push(32'd21, 1'b0);
    w_load = 1'b1;
    w_in1  = 32'd9;
    w_in2  = 32'd9;
    w_in3  = 32'd9;
    @(posedge clk);
    #1;
    w_load = 1'b0;
    chk("t6_ign_w1", m_w1, 32'd0);
    chk("t6_ign_w3", m_w3, 32'd2);
    m_ready = 1'b0;
    push(32'd22, 1'b0);
    push(32'd23, 1'b0);
    chk_tile("t6_pending", 32'd20, 32'd21, 32'd22, 32'd23, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", 32'(m_valid), 32'd0);
    chk("t6_rst_x1", m_x1, 32'd0);
    chk("t6_rst_w2", m_w2, 32'd0);
    chk("t6_rst_w3", m_w3, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    push(32'd30, 1'b0);
    push(32'd31, 1'b0);
    push(32'd32, 1'b0);
    chk("t6_restart_prime", 32'(m_valid), 32'd0);
    push(32'd33, 1'b0);
    chk_tile("t6_restart", 32'd30, 32'd31, 32'd32, 32'd33, 1'b0);
    push(32'd34, 1'b0);
    push(32'd35, 1'b1);
    chk_tile("t6_end", 32'd32, 32'd33, 32'd34, 32'd35, 1'b1);
    idle_cycle();
    chk("t6_drained", 32'(m_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
